// File: rtl/radix4fft_stream_ctrl.sv
// Streaming controller for a shared combinational radix-4 FFT core.
// Gathers four time-domain samples, lets the core settle for one cycle,
// captures all eight core results, then drains the four bins downstream
// under a valid/ready handshake. The controller does no arithmetic on data.
module radix4fft_stream_ctrl #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] core_x_0,
  output logic [DW-1:0] core_x_1,
  output logic [DW-1:0] core_x_2,
  output logic [DW-1:0] core_x_3,
  input  logic [DW-1:0] core_X_real_0,
  input  logic [DW-1:0] core_X_real_1,
  input  logic [DW-1:0] core_X_real_2,
  input  logic [DW-1:0] core_X_real_3,
  input  logic [DW-1:0] core_X_imag_0,
  input  logic [DW-1:0] core_X_imag_1,
  input  logic [DW-1:0] core_X_imag_2,
  input  logic [DW-1:0] core_X_imag_3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic [1:0]    out_index,
  output logic          out_last,
  output logic          busy,
  output logic [7:0]    frame_count
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    load_cnt_reg;
  logic [1:0]    idx_reg;
  logic [7:0]    frame_count_reg;
  logic [DW-1:0] sample_reg   [4];
  logic [DW-1:0] res_real_reg [4];
  logic [DW-1:0] res_imag_reg [4];
  logic [DW-1:0] core_real    [4];
  logic [DW-1:0] core_imag    [4];
  logic          in_fire;
  logic          out_fire;

  // Gather the core result ports into arrays so capture can be a loop.
  assign core_real[0] = core_X_real_0;
  assign core_real[1] = core_X_real_1;
  assign core_real[2] = core_X_real_2;
  assign core_real[3] = core_X_real_3;
  assign core_imag[0] = core_X_imag_0;
  assign core_imag[1] = core_X_imag_1;
  assign core_imag[2] = core_X_imag_2;
  assign core_imag[3] = core_X_imag_3;

  // The core sees the sample registers directly, all the time.
  assign core_x_0 = sample_reg[0];
  assign core_x_1 = sample_reg[1];
  assign core_x_2 = sample_reg[2];
  assign core_x_3 = sample_reg[3];

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign out_index   = idx_reg;
  assign frame_count = frame_count_reg;

  // State register; reset always returns to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake/output decode. in_ready is masked by rst so
  // no sample is offered as accepted while reset is held.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_real   = '0;
    out_imag   = '0;
    busy       = 1'b0;
    case (state_reg)
      LOAD: begin
        in_ready = !rst;
        if (in_valid && !rst && load_cnt_reg == 2'd3) begin
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        busy       = 1'b1;
        state_next = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_real  = res_real_reg[idx_reg];
        out_imag  = res_imag_reg[idx_reg];
        out_last  = (idx_reg == 2'd3);
        if (out_ready && idx_reg == 2'd3) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Sample slots: each accepted transfer fills the slot at load_cnt; the
  // 2-bit counter wraps to 0 on the fourth transfer, clearing it for the
  // next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_reg <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        sample_reg[i] <= '0;
      end
    end else if (in_fire) begin
      sample_reg[load_cnt_reg] <= in_data;
      load_cnt_reg             <= load_cnt_reg + 2'd1;
    end
  end

  // Snapshot all eight core outputs at the end of the single COMPUTE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        res_real_reg[i] <= '0;
        res_imag_reg[i] <= '0;
      end
    end else if (state_reg == COMPUTE) begin
      for (int i = 0; i < 4; i++) begin
        res_real_reg[i] <= core_real[i];
        res_imag_reg[i] <= core_imag[i];
      end
    end
  end

  // Bin index advances per accepted bin; the last bin closes the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg         <= 2'd0;
      frame_count_reg <= 8'd0;
    end else if (out_fire) begin
      idx_reg <= idx_reg + 2'd1;
      if (idx_reg == 2'd3) begin
        frame_count_reg <= frame_count_reg + 8'd1;
      end
    end
  end

endmodule
